// File: rtl/uv_debounce_pkg.sv
// Shared helpers for the misc I/O blocks: ceiling-log2 for register sizing and the unit delay.
package uv_debounce_pkg;

    localparam int UDLY = 1;

    // Never returns less than 1, so a count range of 1 still gets a real register bit.
    function automatic int uv_clog2(input int value);
        int result;
        result = 1;
        while ((1 << result) < value) begin
            result = result + 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/uv_debounce_bit.sv
// One debounced bit: consecutive-sample counter, filtered level, registered rise/fall pulses.
// Level updates on the tick that completes DEB_CNT differing samples; bypass follows i_in after 1 cycle.
module uv_debounce_bit
    import uv_debounce_pkg::*;
#(
    parameter int   DEB_CNT = 4,
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_deb_en,
    input  logic i_tick,
    input  logic i_in,
    output logic o_out,
    output logic o_rise,
    output logic o_fall
);

    localparam int            CW      = uv_clog2(DEB_CNT);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEB_CNT - 1);

    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_cnt_nxt;
    logic          r_out;
    logic          w_out_nxt;
    logic          r_rise;
    logic          r_fall;

    always_comb begin
        w_cnt_nxt = r_cnt;
        w_out_nxt = r_out;
        if (!i_deb_en) begin
            w_cnt_nxt = '0;
            w_out_nxt = i_in;
        end else if (i_tick) begin
            if (i_in == r_out) begin
                w_cnt_nxt = '0;
            end else if (r_cnt == CNT_MAX) begin
                w_out_nxt = i_in;
                w_cnt_nxt = '0;
            end else begin
                w_cnt_nxt = r_cnt + 1'b1;
            end
        end
    end

    // Pulses come from the next level so they line up with the first cycle o_out shows it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt  <= '0;
            r_out  <= RST_VAL;
            r_rise <= 1'b0;
            r_fall <= 1'b0;
        end else begin
            r_cnt  <= w_cnt_nxt;
            r_out  <= w_out_nxt;
            r_rise <= w_out_nxt & ~r_out;
            r_fall <= ~w_out_nxt & r_out;
        end
    end

    assign o_out  = r_out;
    assign o_rise = r_rise;
    assign o_fall = r_fall;

endmodule

// File: rtl/uv_debounce.sv
// Per-bit debouncer and edge detector behind the synchronizer; shared prescaler feeds one tick to all bits.
// Accepts a stable change within DEB_CNT*PRESCALE + PRESCALE-1 cycles; bypass (deb_en=0) is 1 cycle.
module uv_debounce
    import uv_debounce_pkg::*;
#(
    parameter int               WIDTH    = 1,
    parameter int               PRESCALE = 1000,
    parameter int               DEB_CNT  = 4,
    parameter logic [WIDTH-1:0] RST_VAL  = {WIDTH{1'b0}}
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             deb_en,
    input  logic [WIDTH-1:0] in,
    output logic [WIDTH-1:0] out,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall,
    output logic             chg
);

    localparam int            PW      = uv_clog2(PRESCALE);
    localparam logic [PW-1:0] PRE_MAX = PW'(PRESCALE - 1);

    logic [PW-1:0] r_pre_cnt;
    logic          w_tick;

    assign w_tick = (r_pre_cnt == PRE_MAX);

    // Held at zero while bypassed so re-enable always starts a full sample period.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pre_cnt <= '0;
        end else if (!deb_en || w_tick) begin
            r_pre_cnt <= '0;
        end else begin
            r_pre_cnt <= r_pre_cnt + 1'b1;
        end
    end

    for (genvar g = 0; g < WIDTH; g++) begin : g_bit
        uv_debounce_bit #(
            .DEB_CNT (DEB_CNT),
            .RST_VAL (RST_VAL[g])
        ) u_bit (
            .clk      (clk),
            .rst_n    (rst_n),
            .i_deb_en (deb_en),
            .i_tick   (w_tick),
            .i_in     (in[g]),
            .o_out    (out[g]),
            .o_rise   (rise[g]),
            .o_fall   (fall[g])
        );
    end

    assign chg = |(rise | fall);

endmodule
